// File: rtl/mem_ctrl_responder_pkg.sv
`default_nettype none
// ============================================================================
// mem_ctrl_responder_pkg : shared types for the cache-to-RAM responder. Rev 1.0
// ============================================================================
package mem_ctrl_responder_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef logic [2:0] MemCtl_t;
  localparam MemCtl_t MC_IDLE   = 3'd0;
  localparam MemCtl_t MC_IFETCH = 3'd1;
  localparam MemCtl_t MC_DREAD  = 3'd2;
  localparam MemCtl_t MC_DWRITE = 3'd3;
  localparam MemCtl_t MC_RESP   = 3'd4;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } Grant_t;

endpackage
`default_nettype wire

// File: rtl/mem_ctrl_arbiter.sv
`default_nettype none
// ============================================================================
// mem_ctrl_arbiter : icache/dcache priority select with anti-starvation count. Rev 1.0
// ============================================================================
module mem_ctrl_arbiter
  import mem_ctrl_responder_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic    CLK,
  input  logic    nRST,
  input  logic    arb_en,
  input  logic    iREN,
  input  logic    dREN,
  input  logic    dWEN,
  output Grant_t  grant,
  output MemCtl_t next_state
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_cnt;
  logic          starve_hit;

  assign starve_hit = iREN && (starve_cnt == SW'(STARVE_MAX));

  // A write beats a read when both dcache strobes are up.
  always_comb begin
    grant      = GNT_D;
    next_state = MC_IDLE;
    if (starve_hit) begin
      grant      = GNT_I;
      next_state = MC_IFETCH;
    end else if (dWEN) begin
      next_state = MC_DWRITE;
    end else if (dREN) begin
      next_state = MC_DREAD;
    end else if (iREN) begin
      grant      = GNT_I;
      next_state = MC_IFETCH;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      starve_cnt <= '0;
    end else if (arb_en) begin
      if (!iREN || grant == GNT_I) begin
        starve_cnt <= '0;
      end else if (next_state != MC_IDLE && starve_cnt != SW'(STARVE_MAX)) begin
        starve_cnt <= starve_cnt + SW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_ctrl_responder.sv
`default_nettype none
// ============================================================================
// mem_ctrl_responder : sequences one cache word access at a time onto RAM. Rev 1.0
// ============================================================================
module mem_ctrl_responder
  import mem_ctrl_responder_pkg::*;
#(
  parameter int          TIMEOUT_CYC = 64,
  parameter int          STARVE_MAX  = 4,
  parameter logic [31:0] ERR_WORD    = 32'hBAD1BAD1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        merr
);

  localparam int TW = $clog2(TIMEOUT_CYC) + 1;

  MemCtl_t       state;
  MemCtl_t       next_state;
  Grant_t        grant;
  logic [TW-1:0] tmo_cnt;
  logic          ram_done;
  logic          ram_fail;
  logic [31:0]   rd_word;

  mem_ctrl_arbiter #(
    .STARVE_MAX (STARVE_MAX)
  ) u_arbiter (
    .CLK        (CLK),
    .nRST       (nRST),
    .arb_en     (state == MC_IDLE),
    .iREN       (iREN),
    .dREN       (dREN),
    .dWEN       (dWEN),
    .grant      (grant),
    .next_state (next_state)
  );

  // ACCESS wins over a timeout that expires in the same cycle.
  assign ram_done = (ramstate_t'(ramstate) == ACCESS);
  assign ram_fail = (ramstate_t'(ramstate) == ERROR) || (tmo_cnt == TW'(TIMEOUT_CYC - 1));
  assign rd_word  = ram_done ? ramload : ERR_WORD;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= MC_IDLE;
      tmo_cnt  <= '0;
      iwait    <= 1'b1;
      dwait    <= 1'b1;
      iload    <= '0;
      dload    <= '0;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= '0;
      ramstore <= '0;
      merr     <= 1'b0;
    end else begin
      case (state)
        MC_IDLE: begin
          if (next_state != MC_IDLE) begin
            state   <= next_state;
            tmo_cnt <= '0;
            ramaddr <= (grant == GNT_I) ? iaddr : daddr;
            ramREN  <= (next_state != MC_DWRITE);
            ramWEN  <= (next_state == MC_DWRITE);
            if (next_state == MC_DWRITE) begin
              ramstore <= dstore;
            end
          end
        end
        MC_IFETCH, MC_DREAD, MC_DWRITE: begin
          if (ram_done || ram_fail) begin
            state  <= MC_RESP;
            ramREN <= 1'b0;
            ramWEN <= 1'b0;
            merr   <= !ram_done;
            if (state == MC_IFETCH) begin
              iwait <= 1'b0;
              iload <= rd_word;
            end else begin
              dwait <= 1'b0;
              dload <= (state == MC_DWRITE) ? 32'd0 : rd_word;
            end
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        MC_RESP: begin
          iwait <= 1'b1;
          dwait <= 1'b1;
          merr  <= 1'b0;
          state <= MC_IDLE;
        end
        default: state <= MC_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl_responder.sv
`default_nettype none
// ============================================================================
// tb_mem_ctrl_responder : transaction-level random/directed check of the responder. Rev 1.0
// ============================================================================
module tb_mem_ctrl_responder;
  import mem_ctrl_responder_pkg::*;

  localparam int          TIMEOUT_CYC = 64;
  localparam int          STARVE_MAX  = 4;
  localparam logic [31:0] ERR_WORD    = 32'hBAD1BAD1;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN, merr;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int checks = 0;
  int errors = 0;
  int starve = 0;

  mem_ctrl_responder #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .STARVE_MAX  (STARVE_MAX),
    .ERR_WORD    (ERR_WORD)
  ) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dwait    (dwait),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate),
    .merr     (merr)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference grant decision: 0 none, 1 ifetch, 2 dread, 3 dwrite.
  function automatic int model_grant(input logic ir, input logic dr, input logic dw);
    int op;
    if (ir && starve == STARVE_MAX) op = 1;
    else if (dw)                    op = 3;
    else if (dr)                    op = 2;
    else if (ir)                    op = 1;
    else                            op = 0;
    if (!ir || op == 1)             starve = 0;
    else if (starve < STARVE_MAX)   starve = starve + 1;
    return op;
  endfunction

  // Entered and left at #1 after a rising edge with the DUT idle.
  // kind: 0 = ACCESS after nbusy BUSY cycles, 1 = ERROR after nbusy, 2 = never answers.
  task automatic run_txn(input logic ir, input logic dr, input logic dw,
                         input logic [31:0] ia, input logic [31:0] da, input logic [31:0] ds,
                         input int kind, input int nbusy, input logic [31:0] ld,
                         input logic withdraw);
    int          op;
    logic        err;
    logic [31:0] exp_data;
    iREN = ir; dREN = dr; dWEN = dw;
    iaddr = ia; daddr = da; dstore = ds;
    ramstate = FREE;
    op = model_grant(ir, dr, dw);
    @(posedge CLK); #1;
    if (op == 0) begin
      check_eq("idle_quiet", 32'({ramREN, ramWEN, iwait, dwait, merr}), 32'b00110);
      return;
    end
    check_eq("strobe", 32'({ramREN, ramWEN}), (op == 3) ? 32'b01 : 32'b10);
    check_eq("ramaddr", ramaddr, (op == 1) ? ia : da);
    if (op == 3) check_eq("ramstore", ramstore, ds);
    if (withdraw) begin
      iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    end
    for (int cyc = 0; cyc < TIMEOUT_CYC; cyc++) begin
      if (kind != 2 && cyc == nbusy) begin
        ramstate = (kind == 0) ? ACCESS : ERROR;
        ramload  = ld;
      end else begin
        ramstate = BUSY;
        ramload  = $urandom;
      end
      @(posedge CLK); #1;
      if ((kind != 2 && cyc == nbusy) || (kind == 2 && cyc == TIMEOUT_CYC - 1)) break;
      check_eq("in_access", 32'({iwait, dwait, merr, ramREN | ramWEN}), 32'b1101);
    end
    ramstate = FREE;
    err      = (kind != 0);
    exp_data = (op == 3) ? 32'd0 : (err ? ERR_WORD : ld);
    check_eq("resp_wait", 32'({iwait, dwait}), (op == 1) ? 32'b01 : 32'b10);
    check_eq("resp_merr", 32'(merr), 32'(err));
    check_eq("resp_strobe_off", 32'({ramREN, ramWEN}), 32'd0);
    if (op == 1) check_eq("iload", iload, exp_data);
    else         check_eq("dload", dload, exp_data);
    @(posedge CLK); #1;
    check_eq("post_resp", 32'({iwait, dwait, merr}), 32'b110);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nRST = 1'b0;
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
    repeat (2) @(posedge CLK);
    #1;
    check_eq("rst_waits", 32'({iwait, dwait}), 32'b11);
    check_eq("rst_loads", iload | dload, 32'd0);
    check_eq("rst_ram", 32'({ramREN, ramWEN, merr}), 32'd0);
    check_eq("rst_ramaddr", ramaddr | ramstore, 32'd0);
    nRST = 1'b1;
    @(posedge CLK); #1;

    // Fetch answered on the first strobe cycle.
    run_txn(1, 0, 0, 32'h40, 32'h0, 32'h0, 0, 0, 32'h8C220004, 0);
    // Write alongside a pending fetch; fetch follows.
    run_txn(1, 0, 1, 32'h40, 32'h3000, 32'hDEADBEEF, 0, 1, 32'h0, 0);
    run_txn(1, 0, 0, 32'h44, 32'h3000, 32'h0, 0, 2, 32'h12345678, 0);
    // Continuous dREN with iREN: four dcache grants, then icache.
    for (int k = 0; k < 6; k++)
      run_txn(1, 1, 0, 32'h40, 32'h3000, 32'h0, 0, 0, 32'h1000 + 32'(k), 0);
    // RAM never answers: timeout.
    run_txn(0, 1, 0, 32'h0, 32'h3004, 32'h0, 2, 0, 32'h0, 0);
    // RAM error on a fetch.
    run_txn(1, 0, 0, 32'h80, 32'h0, 32'h0, 1, 0, 32'h0, 0);

    // Reset mid-DREAD aborts at once; pending request then re-arbitrated.
    iREN = 1'b0; dREN = 1'b1; dWEN = 1'b0; daddr = 32'h5000;
    void'(model_grant(0, 1, 0));
    @(posedge CLK); #1;
    ramstate = BUSY;
    check_eq("pre_rst_ren", 32'(ramREN), 32'd1);
    #2;
    nRST = 1'b0;
    #1;
    check_eq("rst_abort_ren", 32'({ramREN, ramWEN}), 32'd0);
    check_eq("rst_abort_wait", 32'({iwait, dwait, merr}), 32'b110);
    starve = 0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    run_txn(0, 1, 0, 32'h0, 32'h5000, 32'h0, 0, 1, 32'hCAFEF00D, 0);

    // Randomized traffic.
    for (int n = 0; n < 80; n++) begin
      int kr, kind;
      kr   = $urandom_range(0, 19);
      kind = (kr < 15) ? 0 : ((kr < 19) ? 1 : 2);
      run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
              $urandom, $urandom, $urandom, kind, $urandom_range(0, 4), $urandom,
              1'($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
